uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- Serialises bytes from the CPU's memory-mapped UART path onto the `serial_out` pin: 8N1 framing, LSB first.
- It is the transmit-side counterpart of the on-chip UART receiver that drives the CPU's `serial_in`.
- Byte intake uses a ready/valid handshake; bit timing comes from a cycle counter derived from clock and baud parameters.
- Sits between the CPU's UART MMIO logic and the top-level `serial_out` port.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in bits/s.
- SYMBOL_EDGE_TIME (localparam), CLOCK_FREQ/BAUD_RATE (integer divide), clock cycles per bit. Must be >= 2.
- CLOCK_COUNTER_WIDTH (localparam), $clog2(SYMBOL_EDGE_TIME), width of the bit-period counter.

Ports:
- clk  input  1  core clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  8  byte to transmit; sampled only on handshake.
- data_in_valid  input  1  producer has a byte.
- data_in_ready  output  1  transmitter can accept a byte. High only in IDLE.
- serial_out  output  1  UART line. Idles high.
- tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.

Behaviour:
- Reset: on any posedge with rst=1, enter IDLE.
  - Next cycle: serial_out=1, data_in_ready=1, tx_busy=0.
  - Bit counter, cycle counter and shift register cleared.
  - Reset mid-frame aborts the frame; line returns high the cycle after rst is sampled. No partial resume.
- Handshake: a byte is accepted at a posedge where data_in_valid && data_in_ready.
  - data_in is latched into a 10-bit shift register {1'b1, data_in, 1'b0}.
  - data_in_ready drops the following cycle.
  - data_in is a don't-care at all other times and is never re-sampled mid-frame.
- States: IDLE -> SHIFT -> IDLE.
  - IDLE: serial_out=1, data_in_ready=1. On acceptance go to SHIFT, bit index 0, cycle counter 0.
  - SHIFT: serial_out = shift_reg[0], registered.
    - The cycle counter increments each cycle.
    - When it reaches SYMBOL_EDGE_TIME-1: reset it to 0, shift right, increment bit index.
    - When bit index 9 (stop bit) completes its period, go to IDLE.
- Timing: with acceptance at edge k:
  - Start bit (0) drives cycles k+1 .. k+N, where N = SYMBOL_EDGE_TIME.
  - Data bit i drives cycles k+1+(i+1)N .. k+(i+2)N.
  - Stop bit (1) drives k+9N+1 .. k+10N.
  - Each bit is held exactly N cycles, with no jitter or drift.
- Back-to-back: IDLE is entered at cycle k+10N+1 with data_in_ready=1.
  - If data_in_valid is held, the next byte is accepted at the end of that cycle.
  - Its start bit begins at k+10N+2, giving exactly one extra idle-high cycle between frames.
- serial_out is driven from a flop, never combinationally from inputs, so the pin is glitch-free.
- data_in_valid asserted while busy is ignored. There is no buffering; the producer must hold valid until ready.
- tx_busy = (state == SHIFT).

Test Plan:
- Reset: hold rst 3 cycles mid-idle -> serial_out=1, data_in_ready=1, tx_busy=0 on the first cycle after rst deasserts.
- Single byte: CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (N=10), send 8'hA5 -> sample serial_out at each bit's midpoint.
  - Required sequence: 0, 1,0,1,0,0,1,0,1, 1.
  - Falling edge exactly 1 cycle after the handshake; frame length 100 cycles.
- Ready protocol: assert valid with 8'h3C, then change data_in to 8'hFF during the frame -> transmitted bits still decode to 8'h3C.
  - data_in_ready stays low for 100 cycles and returns high at cycle 101.
- Back-to-back: hold valid with 8'h00 then 8'hFF.
  - Exactly one idle-high cycle between the first stop bit and the second start bit.
  - Both bytes decode correctly via a bench-side reference UART receiver.
- Reset mid-frame: accept 8'h55, assert rst at cycle 35 (inside data bit 2).
  - serial_out=1 the next cycle and stays high with no further edges.
  - A new byte 8'h81 then transmits correctly.
- Default params: CLOCK_FREQ=50_000_000, BAUD_RATE=115_200 -> each bit period measures 434 cycles; byte 8'h41 decoded by the receiver model.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte on a ready/valid handshake and shifts it
// out LSB first, start bit low and stop bit high, with every bit held N clocks.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_CYCLE =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [3:0] STOP_BIT = 4'd9;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                         state_q, state_d;
  logic [9:0]                     shift_q, shift_d;
  logic [3:0]                     bit_idx_q, bit_idx_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                           serial_q, serial_d;

  // NOTE: every variable gets its default before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          state_d     = SHIFT;
          shift_d     = {1'b1, data_in, 1'b0};
          bit_idx_d   = 4'd0;
          cycle_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (cycle_cnt_q == LAST_CYCLE) begin
          cycle_cnt_d = '0;
          shift_d     = {1'b1, shift_q[9:1]};
          bit_idx_d   = bit_idx_q + 4'd1;
          if (bit_idx_q == STOP_BIT) begin
            state_d   = IDLE;
            bit_idx_d = 4'd0;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line flop loads the bit it will show next cycle, so the start bit
    // appears exactly one cycle after the handshake edge.
    serial_d = (state_d == SHIFT) ? shift_d[0] : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= 4'd0;
      cycle_cnt_q <= '0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      cycle_cnt_q <= cycle_cnt_d;
      serial_q    <= serial_d;
    end
  end

  assign data_in_ready = (state_q == IDLE);
  assign tx_busy       = (state_q == SHIFT);
  assign serial_out    = serial_q;

endmodule
